mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port unified memory between the instruction-fetch path (IF) and the data-memory path (MEM stage) of the 5-stage pipeline.
- Serialises requests through a fixed-latency access FSM and returns read data with a one-cycle ready pulse.
- Drives per-requester stall signals that the PC, IF/ID and later pipeline buffers use as enables.
- Data requests have priority; a starvation counter guarantees forward progress for fetch.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MEM_LATENCY, 2, cycles from mem_en to mem_rdata valid; legal range >= 1 (1 = combinational read)
- STARVE_LIMIT, 4, max consecutive DM grants while if_req is pending before IF is forced; legal range >= 1

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- if_req  in  1  fetch request; held with if_addr stable until if_ready
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetched word, registered
- if_ready  out  1  one-cycle pulse, if_rdata valid
- dm_req  in  1  data request; held with dm_addr, dm_we, dm_wdata stable until dm_ready
- dm_we  in  1  1 = write, 0 = read
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  write data
- dm_rdata  out  DATA_W  read data, registered
- dm_ready  out  1  one-cycle pulse, access complete
- stall_if  out  1  if_req & ~if_ready, combinational
- stall_mem  out  1  dm_req & ~dm_ready, combinational
- mem_en  out  1  memory access strobe, registered, exactly one cycle per access
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_rdata  in  DATA_W  memory read data
- busy  out  1  state != IDLE

Behaviour:
- Reset is one clock, synchronous, active-high, and forces:
  - state = IDLE
  - mem_en, mem_we, if_ready, dm_ready = 0
  - mem_addr, mem_wdata, if_rdata, dm_rdata = 0
  - latency counter = 0, starvation counter = 0, owner = IF
- Reset mid-access abandons the access. A write already strobed is not recalled. Requests still held after reset release are re-arbitrated from IDLE.
- FSM states:
  - IDLE: on an edge with any request pending, grant one requester. Latch owner, address, we and wdata into the mem_* registers, set mem_en = 1, load counter = MEM_LATENCY-1, go to ACCESS. With no request, stay in IDLE with mem_en = 0.
  - ACCESS: mem_en = 0 after its first cycle. Count down each cycle. In the cycle where counter == 0:
    - sample mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged);
    - set the owner's ready = 1 for the next cycle;
    - go to RESP.
  - RESP: owner's ready is high for exactly this cycle. Go to IDLE unconditionally; the requester updates or drops req at the following edge, so no re-grant of a completed request occurs.
- Timing:
  - Let R be the first IDLE cycle with req high. mem_en is high in cycle R+1 and ready is high in cycle R+1+MEM_LATENCY.
  - Sustained throughput is one access per MEM_LATENCY+2 cycles.
- Grant priority:
  - DM wins over IF, except that IF wins when the starvation counter == STARVE_LIMIT.
  - Starvation counter increments on each DM grant while if_req = 1.
  - Starvation counter clears on any IF grant, or on an arbitration where if_req = 0.
  - Counter saturates at STARVE_LIMIT.
- The non-owner's ready is never asserted, and the non-owner's rdata holds.
- The stall outputs depend only on req/ready, so a requester stalls from its first request cycle until its ready cycle inclusive-exclusive (stall low in the ready cycle).

Decomposition:
- Shared package/include mem_arb_pkg holds:
  - state encodings ST_IDLE, ST_ACCESS, ST_RESP (2-bit);
  - owner encodings OWN_IF = 0, OWN_DM = 1.
- One sub-module, mem_arb_priority: combinational grant select plus the registered starvation counter. Inputs: if_req, dm_req, arb_en. Output: grant_owner.

Test Plan:
- Single IF read, addr 0x10, MEM_LATENCY=2, model returns 0xDEADBEEF -> mem_en high 1 cycle with mem_addr=0x10, mem_we=0; if_ready pulses in cycle R+3 with if_rdata=0xDEADBEEF; stall_if high in cycles R..R+2.
- if_req and dm_req (read 0x40 -> 0xCAFE0001) raised together -> DM served first: dm_ready at R+3, then IF arbitrated at R+4 with if_ready at R+7 (MEM_LATENCY+2 spacing); dm_rdata=0xCAFE0001.
- DM write, addr 0x20, data 0x12345678 -> one cycle with mem_en=1, mem_we=1, mem_wdata=0x12345678; dm_ready pulse; dm_rdata unchanged from its prior value.
- STARVE_LIMIT=4, dm_req and if_req both held continuously -> grant sequence DM,DM,DM,DM,IF,DM,DM,DM,DM,IF.
- Reset asserted in ACCESS with counter != 0 -> next cycle busy=0, mem_en=0, no ready pulse; after release, the held request is granted again and completes normally.
- MEM_LATENCY=1 with back-to-back IF requests -> ready in R+2, next mem_en in R+4; mem_rdata is sampled in the same cycle as mem_en.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared state and owner encodings for the memory port arbiter
package mem_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_ACCESS = 2'd1, ST_RESP = 2'd2} state_t;
  typedef enum logic {OWN_IF = 1'b0, OWN_DM = 1'b1} owner_t;
endpackage

// File: rtl/mem_arb_priority.sv
// mem_arb_priority: data-first grant select with a starvation override for fetch
module mem_arb_priority
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic if_req,
  input  logic dm_req,
  input  logic arb_en,
  output logic grant_owner
);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] starve;
  logic starved;
  assign starved = starve == CW'(STARVE_LIMIT);
  assign grant_owner = (dm_req && !(if_req && starved)) ? OWN_DM : OWN_IF;
  // a DM grant with if_req pending never happens once starved, so the count saturates on its own
  always_ff @(posedge clk)
    if (reset) starve <= '0;
    else if (arb_en && (if_req || dm_req))
      starve <= (grant_owner == OWN_IF || !if_req) ? '0 : starve + CW'(1);
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises fetch and data accesses onto one fixed-latency single-port memory
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MEM_LATENCY  = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ready,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  localparam int LW = MEM_LATENCY > 1 ? $clog2(MEM_LATENCY) : 1;
  state_t state, state_n;
  logic owner, grant_owner, go, done;
  logic [LW-1:0] cnt;
  assign go        = state == ST_IDLE && (if_req || dm_req);
  assign done      = state == ST_ACCESS && cnt == '0;
  assign busy      = state != ST_IDLE;
  assign stall_if  = if_req && !if_ready;
  assign stall_mem = dm_req && !dm_ready;
  mem_arb_priority #(.STARVE_LIMIT(STARVE_LIMIT)) u_prio (
    .clk(clk),
    .reset(reset),
    .if_req(if_req),
    .dm_req(dm_req),
    .arb_en(state == ST_IDLE),
    .grant_owner(grant_owner)
  );
  // RESP always returns to IDLE so a completed request is never re-granted
  always_comb
    state_n = state == ST_IDLE   ? (go ? ST_ACCESS : ST_IDLE) :
              state == ST_ACCESS ? (done ? ST_RESP : ST_ACCESS) : ST_IDLE;
  always_ff @(posedge clk) state <= reset ? ST_IDLE : state_n;
  always_ff @(posedge clk)
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ready  <= 1'b0;
      dm_ready  <= 1'b0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
      cnt       <= '0;
      owner     <= OWN_IF;
    end else begin
      mem_en   <= go;
      if_ready <= done && owner == OWN_IF;
      dm_ready <= done && owner == OWN_DM;
      if (go) begin
        owner     <= grant_owner;
        mem_we    <= grant_owner == OWN_DM && dm_we;
        mem_addr  <= grant_owner == OWN_DM ? dm_addr : if_addr;
        mem_wdata <= dm_wdata;
        cnt       <= LW'(MEM_LATENCY - 1);
      end else if (cnt != '0) cnt <= cnt - LW'(1);
      if (done && owner == OWN_IF) if_rdata <= mem_rdata;
      if (done && owner == OWN_DM && !mem_we) dm_rdata <= mem_rdata;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_mem_port_arbiter;
  localparam int L = 2;
  localparam int LIM = 4;
  logic clk = 0, reset = 1;
  logic if_req = 0, dm_req = 0, dm_we = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata, mem_rdata;
  logic if_ready, dm_ready, stall_if, stall_mem, mem_en, mem_we, busy;
  logic [31:0] f_if_rdata, f_dm_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
  logic f_if_ready, f_dm_ready, f_stall_if, f_stall_mem, f_mem_en, f_mem_we, f_busy;
  int total = 0, bad = 0;
  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(L), .STARVE_LIMIT(LIM)) dut (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_ready(if_ready), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready), .stall_if(stall_if), .stall_mem(stall_mem),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy));

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(LIM)) dut_fast (
    .clk(clk), .reset(reset), .if_req(if_req), .if_addr(if_addr), .if_rdata(f_if_rdata),
    .if_ready(f_if_ready), .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(f_dm_rdata), .dm_ready(f_dm_ready), .stall_if(f_stall_if), .stall_mem(f_stall_mem),
    .mem_en(f_mem_en), .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
    .mem_rdata(f_mem_rdata), .busy(f_busy));

  // memory environment: unwritten words read a fixed per-address pattern
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a == 32'h10 ? 32'hDEADBEEF : a == 32'h40 ? 32'hCAFE0001 :
           a == 32'h14 ? 32'h11112222 : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
  endfunction
  logic [31:0] mem [256];
  bit wr [256];
  int age = 0;
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      mem[mem_addr[9:2]] <= mem_wdata;
      wr[mem_addr[9:2]] <= 1'b1;
    end
    age <= mem_en ? 1 : age + 1;
  end
  // read data is valid only in the cycle MEM_LATENCY-1 after the strobe, junk otherwise
  assign mem_rdata = ((mem_en ? 0 : age) == L - 1) ?
                     (wr[mem_addr[9:2]] ? mem[mem_addr[9:2]] : dflt(mem_addr)) : 32'hBAD0BAD0;
  assign f_mem_rdata = f_mem_en ?
                       (wr[f_mem_addr[9:2]] ? mem[f_mem_addr[9:2]] : dflt(f_mem_addr)) : 32'hBAD0BAD0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1; if_req = 0; dm_req = 0; dm_we = 0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if ({mem_en, mem_we, if_ready, dm_ready, busy} !== 5'b0) begin bad++; $display("FAIL reset_flags act=%b req=00000", {mem_en, mem_we, if_ready, dm_ready, busy}); end
    total++; if (mem_addr !== 32'h0) begin bad++; $display("FAIL reset_mem_addr act=%h req=0", mem_addr); end
    total++; if (mem_wdata !== 32'h0) begin bad++; $display("FAIL reset_mem_wdata act=%h req=0", mem_wdata); end
    total++; if (if_rdata !== 32'h0) begin bad++; $display("FAIL reset_if_rdata act=%h req=0", if_rdata); end
    total++; if (dm_rdata !== 32'h0) begin bad++; $display("FAIL reset_dm_rdata act=%h req=0", dm_rdata); end
  endtask

  task automatic test_if_read();
    if_addr = 32'h10; if_req = 1; #1;
    total++; if ({stall_if, mem_en} !== 2'b10) begin bad++; $display("FAIL ifrd_R act=%b req=10", {stall_if, mem_en}); end
    tick();
    total++; if ({mem_en, mem_we, busy, stall_if, if_ready} !== 5'b10110) begin bad++; $display("FAIL ifrd_R1 act=%b req=10110", {mem_en, mem_we, busy, stall_if, if_ready}); end
    total++; if (mem_addr !== 32'h10) begin bad++; $display("FAIL ifrd_addr act=%h req=10", mem_addr); end
    tick();
    total++; if ({mem_en, stall_if, if_ready} !== 3'b010) begin bad++; $display("FAIL ifrd_R2 act=%b req=010", {mem_en, stall_if, if_ready}); end
    tick();
    total++; if ({if_ready, stall_if, dm_ready} !== 3'b100) begin bad++; $display("FAIL ifrd_R3 act=%b req=100", {if_ready, stall_if, dm_ready}); end
    total++; if (if_rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL ifrd_data act=%h req=deadbeef", if_rdata); end
    tick(); if_req = 0;
    total++; if ({if_ready, busy} !== 2'b00) begin bad++; $display("FAIL ifrd_R4 act=%b req=00", {if_ready, busy}); end
  endtask

  task automatic test_priority();
    if_addr = 32'h14; dm_addr = 32'h40; dm_we = 0; if_req = 1; dm_req = 1;
    tick();
    total++; if ({mem_en, mem_addr} !== {1'b1, 32'h40}) begin bad++; $display("FAIL prio_dm_grant act=%b/%h req=1/40", mem_en, mem_addr); end
    tick(); tick();
    total++; if ({dm_ready, if_ready, stall_mem, stall_if} !== 4'b1001) begin bad++; $display("FAIL prio_dm_ready act=%b req=1001", {dm_ready, if_ready, stall_mem, stall_if}); end
    total++; if (dm_rdata !== 32'hCAFE0001) begin bad++; $display("FAIL prio_dm_data act=%h req=cafe0001", dm_rdata); end
    tick(); dm_req = 0;
    total++; if ({dm_ready, busy, mem_en} !== 3'b000) begin bad++; $display("FAIL prio_R4 act=%b req=000", {dm_ready, busy, mem_en}); end
    tick();
    total++; if ({mem_en, mem_addr} !== {1'b1, 32'h14}) begin bad++; $display("FAIL prio_if_grant act=%b/%h req=1/14", mem_en, mem_addr); end
    tick(); tick();
    total++; if ({if_ready, dm_ready} !== 2'b10) begin bad++; $display("FAIL prio_if_ready act=%b req=10", {if_ready, dm_ready}); end
    total++; if ({if_rdata, dm_rdata} !== {32'h11112222, 32'hCAFE0001}) begin bad++; $display("FAIL prio_if_data act=%h/%h req=11112222/cafe0001", if_rdata, dm_rdata); end
    tick(); if_req = 0;
  endtask

  task automatic test_dm_write();
    dm_addr = 32'h20; dm_wdata = 32'h12345678; dm_we = 1; dm_req = 1;
    tick();
    total++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {2'b11, 32'h20, 32'h12345678}) begin bad++; $display("FAIL wr_strobe act=%b%b/%h/%h req=11/20/12345678", mem_en, mem_we, mem_addr, mem_wdata); end
    tick();
    total++; if (mem_en !== 1'b0) begin bad++; $display("FAIL wr_single_strobe act=%b req=0", mem_en); end
    tick();
    total++; if ({dm_ready, dm_rdata} !== {1'b1, 32'hCAFE0001}) begin bad++; $display("FAIL wr_ready act=%b/%h req=1/cafe0001", dm_ready, dm_rdata); end
    tick(); dm_req = 0; dm_we = 0;
    total++; if (mem[8] !== 32'h12345678) begin bad++; $display("FAIL wr_stored act=%h req=12345678", mem[8]); end
  endtask

  task automatic test_starvation();
    int exp_seq[10];
    int n;
    bit if_nx, dm_nx;
    exp_seq = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    n = 0; if_nx = 0; dm_nx = 0;
    do_reset();
    if_addr = 32'h100; dm_addr = 32'h200; dm_we = 0; if_req = 1; dm_req = 1;
    for (int c = 0; c < 200 && n < 10; c++) begin
      tick();
      if (if_nx) if_addr = if_addr + 4;
      if (dm_nx) dm_addr = dm_addr + 4;
      if_nx = if_ready; dm_nx = dm_ready;
      if (mem_en) begin
        total++;
        if (int'(mem_addr >= 32'h200) !== exp_seq[n]) begin bad++; $display("FAIL starve_grant%0d act=%0d req=%0d (1=DM)", n, mem_addr >= 32'h200, exp_seq[n]); end
        n++;
      end
    end
    total++; if (n != 10) begin bad++; $display("FAIL starve_timeout act=%0d grants req=10", n); end
    if_req = 0; dm_req = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    if_addr = 32'h10; if_req = 1;
    tick();
    total++; if (mem_en !== 1'b1) begin bad++; $display("FAIL rstmid_grant act=%b req=1", mem_en); end
    reset = 1;
    tick();
    reset = 0;
    total++; if ({busy, mem_en, if_ready} !== 3'b000) begin bad++; $display("FAIL rstmid_abandon act=%b req=000", {busy, mem_en, if_ready}); end
    tick();
    total++; if ({mem_en, mem_addr, if_ready} !== {1'b1, 32'h10, 1'b0}) begin bad++; $display("FAIL rstmid_regrant act=%b/%h/%b req=1/10/0", mem_en, mem_addr, if_ready); end
    tick();
    total++; if (if_ready !== 1'b0) begin bad++; $display("FAIL rstmid_early act=%b req=0", if_ready); end
    tick();
    total++; if ({if_ready, if_rdata} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL rstmid_done act=%b/%h req=1/deadbeef", if_ready, if_rdata); end
    tick(); if_req = 0;
  endtask

  task automatic test_fast();
    do_reset();
    if_addr = 32'h10; if_req = 1;
    tick();
    total++; if (f_mem_en !== 1'b1) begin bad++; $display("FAIL fast_en1 act=%b req=1", f_mem_en); end
    tick();
    total++; if ({f_if_ready, f_if_rdata} !== {1'b1, 32'hDEADBEEF}) begin bad++; $display("FAIL fast_ready1 act=%b/%h req=1/deadbeef", f_if_ready, f_if_rdata); end
    tick(); if_addr = 32'h14;
    total++; if ({f_mem_en, f_if_ready} !== 2'b00) begin bad++; $display("FAIL fast_gap act=%b req=00", {f_mem_en, f_if_ready}); end
    tick();
    total++; if ({f_mem_en, f_mem_addr} !== {1'b1, 32'h14}) begin bad++; $display("FAIL fast_en2 act=%b/%h req=1/14", f_mem_en, f_mem_addr); end
    tick();
    total++; if ({f_if_ready, f_if_rdata} !== {1'b1, 32'h11112222}) begin bad++; $display("FAIL fast_ready2 act=%b/%h req=1/11112222", f_if_ready, f_if_rdata); end
    tick(); if_req = 0;
  endtask

  task automatic test_random(input int ncyc);
    logic [31:0] rmem [256];
    bit rwr [256];
    int next_arb, en_c, ifr_c, dmr_c, starve;
    logic [31:0] e_addr, e_wdata, e_if, e_dm, p_if, p_dm;
    logic e_we, g_dm;
    bit if_nx, dm_nx;
    next_arb = 0; en_c = -1; ifr_c = -1; dmr_c = -1; starve = 0;
    e_addr = 0; e_wdata = 0; e_we = 0; e_if = 0; e_dm = 0; p_if = 0; p_dm = 0;
    if_nx = 0; dm_nx = 0;
    for (int i = 0; i < 256; i++) rwr[i] = 0;
    do_reset();
    for (int c = 0; c < ncyc; c++) begin
      if (c == ifr_c) e_if = p_if;
      if (c == dmr_c) e_dm = p_dm;
      total++; if (mem_en !== (c == en_c)) begin bad++; $display("FAIL rnd_en c=%0d act=%b req=%b", c, mem_en, c == en_c); end
      if (c == en_c) begin
        total++; if ({mem_addr, mem_we} !== {e_addr, e_we} || (e_we && mem_wdata !== e_wdata)) begin bad++; $display("FAIL rnd_access c=%0d act=%h/%b/%h req=%h/%b/%h", c, mem_addr, mem_we, mem_wdata, e_addr, e_we, e_wdata); end
      end
      total++; if ({if_ready, dm_ready} !== {c == ifr_c, c == dmr_c}) begin bad++; $display("FAIL rnd_ready c=%0d act=%b%b req=%b%b", c, if_ready, dm_ready, c == ifr_c, c == dmr_c); end
      total++; if ({if_rdata, dm_rdata} !== {e_if, e_dm}) begin bad++; $display("FAIL rnd_rdata c=%0d act=%h/%h req=%h/%h", c, if_rdata, dm_rdata, e_if, e_dm); end
      total++; if (busy !== (en_c >= 0 && c >= en_c && c < next_arb)) begin bad++; $display("FAIL rnd_busy c=%0d act=%b", c, busy); end
      // requesters: change only in the cycle after their ready, or raise when idle
      if (if_nx || (!if_req && $urandom_range(0, 2) == 0)) begin
        if_req = if_nx ? 1'($urandom_range(0, 1)) : 1'b1;
        if_addr = 32'h200 + 32'($urandom_range(0, 15)) * 4;
      end
      if (dm_nx || (!dm_req && $urandom_range(0, 2) == 0)) begin
        dm_req = dm_nx ? 1'($urandom_range(0, 1)) : 1'b1;
        dm_addr = 32'h200 + 32'($urandom_range(0, 15)) * 4;
        dm_we = 1'($urandom_range(0, 1));
        dm_wdata = $urandom;
      end
      if_nx = if_ready; dm_nx = dm_ready;
      #1;
      total++; if ({stall_if, stall_mem} !== {if_req && c != ifr_c, dm_req && c != dmr_c}) begin bad++; $display("FAIL rnd_stall c=%0d act=%b%b", c, stall_if, stall_mem); end
      if (c >= next_arb && (if_req || dm_req)) begin
        g_dm = dm_req && !(if_req && starve == LIM);
        starve = (!g_dm || !if_req) ? 0 : (starve < LIM ? starve + 1 : LIM);
        en_c = c + 1; next_arb = c + L + 2;
        if (g_dm) begin
          e_addr = dm_addr; e_we = dm_we; e_wdata = dm_wdata; dmr_c = c + L + 1;
          if (dm_we) begin
            rmem[dm_addr[9:2]] = dm_wdata; rwr[dm_addr[9:2]] = 1; p_dm = e_dm;
          end else p_dm = rwr[dm_addr[9:2]] ? rmem[dm_addr[9:2]] : dflt(dm_addr);
        end else begin
          e_addr = if_addr; e_we = 0; ifr_c = c + L + 1;
          p_if = rwr[if_addr[9:2]] ? rmem[if_addr[9:2]] : dflt(if_addr);
        end
      end
      tick();
    end
    if_req = 0; dm_req = 0;
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_priority();
    test_dm_write();
    test_starvation();
    test_reset_mid();
    test_fast();
    test_random(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
